shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
Transaction controller for the 16-bit SISO shift register (Load/Left/Din/A in; Dout/register out).
- Accepts a request (parallel word, direction, shift count, fill bit) over valid/ready.
- Sequences one-cycle parallel load, then N shift cycles, capturing each bit shifted out on Dout.
- Returns the captured bits plus the final register image over valid/ready.
- The shift register shifts on every Load=0 cycle, so the sequencer freezes it whenever idle by reloading its own image (Load=1, A=register).

Parameters:
WIDTH, 16, shift register width
CNT_W, 5, shift count width, equal to clog2(WIDTH)+1

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request ready
req_data  in  WIDTH  word to parallel-load
req_left  in  1  1 = left shift (out at MSB), 0 = right shift (out at LSB)
req_count  in  CNT_W  shifts to perform, 0..WIDTH; values >WIDTH saturate to WIDTH
req_fill  in  1  Din value during shifts
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  WIDTH  captured bits, bit k = k-th bit shifted out, unused bits 0
rsp_reg  out  WIDTH  register image after last shift
sr_load  out  1  to shift register Load
sr_left  out  1  to shift register Left
sr_din  out  1  to shift register Din
sr_a  out  WIDTH  to shift register A
sr_dout  in  1  from shift register Dout (registered in the shift register)
sr_register  in  WIDTH  from shift register register

Behaviour:
- Clock and reset: one clock Clk; reset Rst_n is synchronous, active-low.
- While Rst_n=0:
  - sr_load=1, sr_a=0; the register clears at that edge.
  - req_ready=0, rsp_valid=0.
  - State goes to IDLE; capture and response registers go to 0.
- Reset mid-transaction aborts it: no response, captured bits discarded.
- States: IDLE, LOAD, SHIFT, DRAIN, DONE. Decoding:
  - IDLE: sr_load=1, sr_a=sr_register (freeze); req_ready=1.
  - IDLE -> LOAD on req_valid&req_ready. Latch data, left, fill and saturated count.
  - LOAD: sr_load=1, sr_a=latched data. Next state is SHIFT if count>0, else DRAIN.
  - SHIFT: sr_load=0, sr_left=latched left, sr_din=latched fill. Stays exactly count cycles, then DRAIN.
  - DRAIN: sr_load=1, sr_a=sr_register (freeze). Latch rsp_reg=sr_register. Then DONE.
  - DONE: freeze as in IDLE; rsp_valid=1; rsp_data and rsp_reg stable. Goes to IDLE on rsp_ready.
- Capture: sr_dout reflects a shift one cycle after that shift's edge.
  - Sample sr_dout in SHIFT cycles 2..count and in DRAIN (only when count>0).
  - Bit index increments from 0.
- sr_left and sr_din are 0 outside SHIFT.
- Latency, with accept edge at cycle T:
  - LOAD at T+1.
  - SHIFT at T+2..T+1+N.
  - DRAIN at T+2+N.
  - rsp_valid at T+3+N.
  - count=0: rsp_valid at T+3.
- No new request is accepted until the response handshake completes (req_ready=0 in LOAD..DONE).
- req_ready and rsp_valid are decoded from registered state only; there is no combinational path from req_valid or rsp_ready.
- rsp_valid and rsp_data must not change while rsp_valid=1 && rsp_ready=0.

Optional Feature:
- SHREG_SEQ_PARITY_EN defined:
  - Adds output rsp_parity (1 bit) = XOR of the captured bits, valid with rsp_valid.
  - rsp_parity is 0 in reset and when count=0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package shift_reg_seq_pkg:
  - state enum (IDLE, LOAD, SHIFT, DRAIN, DONE)
  - WIDTH/CNT_W defaults
  - request struct (data, left, count, fill)
- One sub-module: shift_capture_unit, which holds the bit-index counter and the rsp_data accumulator, with enable/clear inputs.
- FSM stays in the top module.

Test Plan:
- Reset: Rst_n=0 for 2 cycles -> sr_load=1, sr_a=16'h0000, req_ready=0, rsp_valid=0. Then Rst_n=1 -> req_ready=1, sr_register held at 16'h0000 for 10 cycles.
- Right shift: data=16'hA5A5, left=0, count=3, fill=1 -> rsp_valid at T+6, rsp_data=16'h0005, rsp_reg=16'hF4B4.
- Left shift: data=16'hABCD, left=1, count=3, fill=0 -> rsp_data=16'h0005, rsp_reg=16'h5E68. Edge cases:
  - count=0 with data=16'hBEEF -> rsp_valid at T+3, rsp_data=0, rsp_reg=16'hBEEF.
  - count=16 right, data=16'h1234, fill=0 -> rsp_data=16'h1234, rsp_reg=16'h0000.
  - count=31 -> behaves as 16.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_reg stable, sr_register unchanged, req_ready=0. The queued req_valid is accepted only after the response handshake.
- Reset mid-SHIFT: assert Rst_n=0 during shift 2 of a count=8 transaction -> no rsp_valid, sr_register=16'h0000 next cycle, IDLE with req_ready=1 after release.
- With SHREG_SEQ_PARITY_EN: 16'hA5A5 right, count=3 -> rsp_parity=0. Left count=1 on 16'h8000 -> rsp_parity=1.

Source files
------------

// File: rtl/shift_reg_seq_pkg.sv
// Shared types and defaults for the shift register transaction sequencer.
package shift_reg_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 left;
        logic [DEF_CNT_W-1:0] count;
        logic                 fill;
    } req_t;

    // Requests asking for more shifts than the register holds are clamped to a full flush.
    function automatic logic [DEF_CNT_W-1:0] saturate_count(input logic [DEF_CNT_W-1:0] count);
        return (count > DEF_CNT_W'(DEF_WIDTH)) ? DEF_CNT_W'(DEF_WIDTH) : count;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_capture.sv
// Collects the bits shifted out of the register into a response word, LSB first.
module shift_capture_unit
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data
);

    logic [CNT_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx  <= '0;
            data <= '0;
        end else if (enable) begin
            data <= data | (WIDTH'(bit_in) << idx);
            idx  <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Valid/ready transaction controller for a 16-bit SISO shift register.
// Define SHREG_SEQ_PARITY_EN to add the rsp_parity output.
module shift_reg_sequencer
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_left,
    input  logic [CNT_W-1:0] req_count,
    input  logic             req_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_reg,
`ifdef SHREG_SEQ_PARITY_EN
    output logic             rsp_parity,
`endif
    output logic             sr_load,
    output logic             sr_left,
    output logic             sr_din,
    output logic [WIDTH-1:0] sr_a,
    input  logic             sr_dout,
    input  logic [WIDTH-1:0] sr_register
);

    state_t           state_q;
    state_t           state_d;
    req_t             req_q;
    logic [CNT_W-1:0] shift_cnt_q;
    logic [CNT_W-1:0] shift_next;
    logic [WIDTH-1:0] rsp_reg_q;
    logic             accept;
    logic             capture_en;

    assign accept     = req_ready && req_valid;
    assign shift_next = shift_cnt_q + 1'b1;
    assign rsp_reg    = rsp_reg_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            shift_cnt_q <= '0;
            rsp_reg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q.data  <= req_data;
                req_q.left  <= req_left;
                req_q.count <= saturate_count(req_count);
                req_q.fill  <= req_fill;
            end
            if (state_q == LOAD) begin
                shift_cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                shift_cnt_q <= shift_next;
            end
            if (state_q == DRAIN) begin
                rsp_reg_q <= sr_register;
            end
        end
    end

    // Dout lags each shift by a cycle, so the first SHIFT cycle has nothing to sample
    // and DRAIN picks up the bit from the final shift.
    always_comb begin
        state_d    = state_q;
        sr_load    = 1'b1;
        sr_a       = sr_register;
        sr_left    = 1'b0;
        sr_din     = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOAD;
            end
            LOAD: begin
                sr_a    = req_q.data;
                state_d = (req_q.count != '0) ? SHIFT : DRAIN;
            end
            SHIFT: begin
                sr_load    = 1'b0;
                sr_left    = req_q.left;
                sr_din     = req_q.fill;
                capture_en = (shift_cnt_q != '0);
                if (shift_next == req_q.count) state_d = DRAIN;
            end
            DRAIN: begin
                capture_en = (req_q.count != '0);
                state_d    = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset clears the external register through a parallel load of zero.
        if (!Rst_n) begin
            state_d    = IDLE;
            sr_load    = 1'b1;
            sr_a       = '0;
            sr_left    = 1'b0;
            sr_din     = 1'b0;
            req_ready  = 1'b0;
            rsp_valid  = 1'b0;
            capture_en = 1'b0;
        end
    end

    shift_capture_unit #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_capture (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clear (accept),
        .enable(capture_en),
        .bit_in(sr_dout),
        .data  (rsp_data)
    );

`ifdef SHREG_SEQ_PARITY_EN
    assign rsp_parity = ^rsp_data;
`endif

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer with a behavioural SISO shift register and a response scoreboard.
module tb_shift_reg_sequencer;

    typedef struct packed {
        logic [15:0] data;
        logic        left;
        logic [4:0]  count;
        logic        fill;
    } stim_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] img;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic        req_left;
    logic [4:0]  req_count;
    logic        req_fill;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] rsp_reg;
`ifdef SHREG_SEQ_PARITY_EN
    logic        rsp_parity;
`endif
    logic        sr_load;
    logic        sr_left;
    logic        sr_din;
    logic [15:0] sr_a;
    logic        sr_dout = 1'b0;
    logic [15:0] sr_register;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t sb[$];

    stim_t tbl [6] = '{
        '{16'hA5A5, 1'b0, 5'd3,  1'b1},
        '{16'hABCD, 1'b1, 5'd3,  1'b0},
        '{16'hBEEF, 1'b0, 5'd0,  1'b1},
        '{16'h1234, 1'b0, 5'd16, 1'b0},
        '{16'hC3A5, 1'b1, 5'd31, 1'b1},
        '{16'h8000, 1'b1, 5'd1,  1'b0}
    };

    shift_reg_sequencer dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_left   (req_left),
        .req_count  (req_count),
        .req_fill   (req_fill),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_reg    (rsp_reg),
`ifdef SHREG_SEQ_PARITY_EN
        .rsp_parity (rsp_parity),
`endif
        .sr_load    (sr_load),
        .sr_left    (sr_left),
        .sr_din     (sr_din),
        .sr_a       (sr_a),
        .sr_dout    (sr_dout),
        .sr_register(sr_register)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The shift register itself: loads on Load=1, otherwise shifts with registered Dout.
    always @(posedge clk) begin
        if (sr_load) begin
            sr_register <= sr_a;
        end else if (sr_left) begin
            sr_dout     <= sr_register[15];
            sr_register <= {sr_register[14:0], sr_din};
        end else begin
            sr_dout     <= sr_register[0];
            sr_register <= {sr_din, sr_register[15:1]};
        end
    end

    function automatic exp_t ref_model(input logic [15:0] d, input logic l, input logic [4:0] c, input logic f);
        exp_t        e;
        logic [15:0] r;
        int          n;
        r      = d;
        n      = (c > 5'd16) ? 16 : int'(c);
        e.data = '0;
        for (int k = 0; k < n; k++) begin
            e.data[k] = l ? r[15] : r[0];
            r = l ? {r[14:0], f} : {f, r[15:1]};
        end
        e.img = r;
        e.lat = n + 2;
        return e;
    endfunction

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic drive_request(input logic [15:0] d, input logic l, input logic [4:0] c, input logic f);
        int guard = 0;
        req_data  = d;
        req_left  = l;
        req_count = c;
        req_fill  = f;
        req_valid = 1'b1;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        accept_cyc = cyc;
        req_valid  = 1'b0;
        sb.push_back(ref_model(d, l, c, f));
    endtask

    task automatic wait_rsp(output int lat);
        int guard = 0;
        while (rsp_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        lat = cyc - accept_cyc;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic test_reset();
        bit bad = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        req_data  = '0;
        req_left  = 1'b0;
        req_count = '0;
        req_fill  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (sr_load !== 1'b1) begin errors++; $display("[TB] FAIL reset_sr_load got %b want 1", sr_load); end
        if (sr_a !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sr_a got %h want 0000", sr_a); end
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready got %b want 1", req_ready); end
        if (rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_data got %h want 0000", rsp_data); end
        for (int i = 0; i < 10; i++) begin
            if (sr_register !== 16'h0000) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("[TB] FAIL idle_freeze register=%h want 0000", sr_register); end
    endtask

    task automatic test_shift_table();
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            drive_request(tbl[i].data, tbl[i].left, tbl[i].count, tbl[i].fill);
            wait_rsp(lat);
            e = sb.pop_front();
            checks += 3;
            if (lat != e.lat) begin errors++; $display("[TB] FAIL table%0d_latency got %0d want %0d", i, lat, e.lat); end
            if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL table%0d_rsp_data got %h want %h", i, rsp_data, e.data); end
            if (rsp_reg !== e.img) begin errors++; $display("[TB] FAIL table%0d_rsp_reg got %h want %h", i, rsp_reg, e.img); end
`ifdef SHREG_SEQ_PARITY_EN
            checks++;
            if (rsp_parity !== ^e.data) begin errors++; $display("[TB] FAIL table%0d_parity got %b want %b", i, rsp_parity, ^e.data); end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          lat;
        logic [15:0] held_data;
        logic [15:0] held_reg;
        rsp_ready = 1'b0;
        drive_request(16'hA5A5, 1'b0, 5'd3, 1'b1);
        wait_rsp(lat);
        e = sb.pop_front();
        checks += 2;
        if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL bp_rsp_data got %h want %h", rsp_data, e.data); end
        if (rsp_reg !== e.img) begin errors++; $display("[TB] FAIL bp_rsp_reg got %h want %h", rsp_reg, e.img); end
        held_data = e.data;
        held_reg  = e.img;
        req_data  = 16'h0F0F;
        req_left  = 1'b1;
        req_count = 5'd5;
        req_fill  = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 5;
            if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid got %b want 1", rsp_valid); end
            if (rsp_data !== held_data) begin errors++; $display("[TB] FAIL bp_hold_data got %h want %h", rsp_data, held_data); end
            if (rsp_reg !== held_reg) begin errors++; $display("[TB] FAIL bp_hold_reg got %h want %h", rsp_reg, held_reg); end
            if (sr_register !== held_reg) begin errors++; $display("[TB] FAIL bp_hold_register got %h want %h", sr_register, held_reg); end
            if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_req_ready got %b want 0", req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        drive_request(16'h0F0F, 1'b1, 5'd5, 1'b1);
        wait_rsp(lat);
        e = sb.pop_front();
        checks += 3;
        if (lat != e.lat) begin errors++; $display("[TB] FAIL bp2_latency got %0d want %0d", lat, e.lat); end
        if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL bp2_rsp_data got %h want %h", rsp_data, e.data); end
        if (rsp_reg !== e.img) begin errors++; $display("[TB] FAIL bp2_rsp_reg got %h want %h", rsp_reg, e.img); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        bit   seen = 0;
        drive_request(16'h5AC3, 1'b0, 5'd8, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks += 3;
        if (sr_register !== 16'h0000) begin errors++; $display("[TB] FAIL abort_register got %h want 0000", sr_register); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_rsp_valid got %b want 0", rsp_valid); end
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_req_ready got %b want 0", req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle_ready got %b want 1", req_ready); end
        if (rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL abort_rsp_data got %h want 0000", rsp_data); end
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin errors++; $display("[TB] FAIL abort_no_response rsp_valid seen=1 want 0"); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        for (int i = 0; i < 8; i++) begin
            drive_request(16'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom));
            wait_rsp(lat);
            e = sb.pop_front();
            checks += 3;
            if (lat != e.lat) begin errors++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, e.lat); end
            if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL rand%0d_rsp_data got %h want %h", i, rsp_data, e.data); end
            if (rsp_reg !== e.img) begin errors++; $display("[TB] FAIL rand%0d_rsp_reg got %h want %h", i, rsp_reg, e.img); end
`ifdef SHREG_SEQ_PARITY_EN
            checks++;
            if (rsp_parity !== ^e.data) begin errors++; $display("[TB] FAIL rand%0d_parity got %b want %b", i, rsp_parity, ^e.data); end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        $display("[TB] starting shift_reg_sequencer bench");
        test_reset();
        test_shift_table();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
